// File: rtl/comparator_pkg.sv
// Shared types and sizing helpers for the iterative magnitude comparator.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of chunks an operand splits into.
    function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
        return width / chunk;
    endfunction

    // Width of the chunk index counter; at least one bit even for a single chunk.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/comp_chunk.sv
// Purely combinational CHUNK-bit unsigned magnitude compare.
module comp_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/comparator_iter_nbit.sv
// Handshaked WIDTH-bit magnitude comparator scanning CHUNK bits per cycle, MSB chunk first.
module comparator_iter_nbit
    import comparator_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned CHUNK      = 8,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic             busy
);

    localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int unsigned IDX_W  = idx_w(NCHUNK);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] bias;
    logic             gt_r;
    logic             lt_r;
    logic             eq_r;
    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic             c_gt;
    logic             c_lt;
    logic             c_eq;
    logic             decided;
    logic             accept;
    logic             last;

    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == SCAN) || (state == DONE);
    assign gt        = gt_r;
    assign lt        = lt_r;
    assign eq        = eq_r;

    assign accept  = in_valid && in_ready;
    assign decided = gt_r || lt_r;
    assign last    = (idx == '0);

    assign a_c = a_r[32'(idx) * CHUNK +: CHUNK];
    assign b_c = b_r[32'(idx) * CHUNK +: CHUNK];

    comp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a  (a_c),
        .b  (b_c),
        .gt (c_gt),
        .lt (c_lt),
        .eq (c_eq)
    );

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    always_comb begin
        bias            = '0;
        bias[WIDTH-1]   = is_signed;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = SCAN;
            SCAN: if ((EARLY_EXIT && !c_eq) || last) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, chunk index and result flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r  <= '0;
            b_r  <= '0;
            idx  <= '0;
            gt_r <= 1'b0;
            lt_r <= 1'b0;
            eq_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_r  <= a ^ bias;
                        b_r  <= b ^ bias;
                        idx  <= IDX_W'(NCHUNK - 1);
                        gt_r <= 1'b0;
                        lt_r <= 1'b0;
                        eq_r <= 1'b0;
                    end
                end
                SCAN: begin
                    // Only the most significant unequal chunk decides the result.
                    if (!c_eq && !decided) begin
                        gt_r <= c_gt;
                        lt_r <= c_lt;
                    end
                    if (last && c_eq && !decided) eq_r <= 1'b1;
                    if (state_next == SCAN) idx <= idx - 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        gt_r <= 1'b0;
                        lt_r <= 1'b0;
                        eq_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_iter_nbit.sv
// Directed self-checking bench: one early-exit and one fixed-latency instance.
module tb_comparator_iter_nbit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        is_signed;
    logic        in_valid0, in_valid1;
    logic        out_ready0, out_ready1;
    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic        gt0, lt0, eq0, busy0;
    logic        gt1, lt1, eq1, busy1;

    int checks = 0;
    int errors = 0;

    logic sel;
    logic ov, ir, bz;
    logic [2:0] flags;

    always #5 clk = ~clk;

    comparator_iter_nbit #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid0),
        .out_ready(out_ready0), .gt(gt0), .lt(lt0), .eq(eq0), .busy(busy0)
    );

    comparator_iter_nbit #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid1),
        .out_ready(out_ready1), .gt(gt1), .lt(lt1), .eq(eq1), .busy(busy1)
    );

    // View of whichever instance the current test is driving.
    always_comb begin
        ov    = sel ? out_valid1 : out_valid0;
        ir    = sel ? in_ready1  : in_ready0;
        bz    = sel ? busy1      : busy0;
        flags = sel ? {gt1, lt1, eq1} : {gt0, lt0, eq0};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for out_valid; returns edges counted after the accepting edge.
    task automatic wait_result(output int n);
        n = 0;
        while (!ov && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // One full transaction with out_ready held high; exp = {gt,lt,eq}.
    task automatic run_cmp(input logic s, input logic [31:0] va, input logic [31:0] vb,
                           input logic sg, input logic [2:0] exp, input int k, input string tag);
        int n;
        sel = s;
        @(negedge clk);
        check_eq({tag, " in_ready"}, 32'(ir), 32'd1);
        a = va; b = vb; is_signed = sg;
        if (s) in_valid1 = 1'b1; else in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0; in_valid1 = 1'b0;
        a = ~va; b = ~vb; is_signed = ~sg;
        check_eq({tag, " busy"}, 32'(bz), 32'd1);
        wait_result(n);
        check_eq({tag, " latency"}, 32'(n), 32'(k));
        check_eq({tag, " flags"}, 32'(flags), 32'(exp));
        @(posedge clk); #1;
        check_eq({tag, " post ov"}, 32'(ov), 32'd0);
        check_eq({tag, " post flags"}, 32'(flags), 32'd0);
        check_eq({tag, " post in_ready"}, 32'(ir), 32'd1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; a = '0; b = '0; is_signed = 1'b0; sel = 1'b0;
        in_valid0 = 1'b0; in_valid1 = 1'b0; out_ready0 = 1'b1; out_ready1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset outputs0", {27'd0, out_valid0, gt0, lt0, eq0, busy0}, 32'd0);
        check_eq("reset outputs1", {27'd0, out_valid1, gt1, lt1, eq1, busy1}, 32'd0);
        check_eq("reset in_ready", {30'd0, in_ready0, in_ready1}, 32'd0);
        rst_n = 1'b1;

        // {gt,lt,eq}: 4 = gt, 2 = lt, 1 = eq
        run_cmp(1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b0, 3'b100, 1, "u_msb_ee1");
        run_cmp(1'b1, 32'h80000000, 32'h7FFFFFFF, 1'b0, 3'b100, 4, "u_msb_ee0");
        run_cmp(1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b1, 3'b010, 1, "s_min_max");
        run_cmp(1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 3'b010, 1, "s_neg1_zero");
        run_cmp(1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b0, 3'b100, 1, "u_max_zero");
        run_cmp(1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 3'b001, 4, "u_eq");
        run_cmp(1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 3'b001, 4, "s_eq");
        run_cmp(1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 3'b001, 4, "s_eq_ee0");
        run_cmp(1'b0, 32'h12345679, 32'h12345678, 1'b0, 3'b100, 4, "lsb_gt");
        run_cmp(1'b0, 32'h00000000, 32'h00000001, 1'b0, 3'b010, 4, "lsb_lt");
        run_cmp(1'b0, 32'h00010000, 32'h00000000, 1'b0, 3'b100, 2, "chunk2_gt");
        run_cmp(1'b1, 32'h00000000, 32'h00FF0000, 1'b1, 3'b010, 4, "chunk2_lt_ee0");

        // Backpressure on the early-exit instance.
        sel = 1'b0; out_ready0 = 1'b0;
        @(negedge clk);
        a = 32'h00000100; b = 32'h00000200; is_signed = 1'b0; in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        wait_result(n);
        check_eq("bp latency", 32'(n), 32'd3);
        check_eq("bp flags", 32'(flags), 32'd2);
        a = 32'h00000005; b = 32'h00000009; in_valid0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("bp stall ov", 32'(ov), 32'd1);
            check_eq("bp stall flags", 32'(flags), 32'd2);
            check_eq("bp stall in_ready", 32'(ir), 32'd0);
        end
        out_ready0 = 1'b1;
        @(posedge clk); #1;
        check_eq("bp released ov", 32'(ov), 32'd0);
        check_eq("bp released busy", 32'(bz), 32'd0);
        check_eq("bp released in_ready", 32'(ir), 32'd1);
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        check_eq("bp next accept busy", 32'(bz), 32'd1);
        wait_result(n);
        check_eq("bp next latency", 32'(n), 32'd4);
        check_eq("bp next flags", 32'(flags), 32'd2);
        @(posedge clk); #1;

        // Reset during the second SCAN cycle of the fixed-latency instance.
        sel = 1'b1;
        @(negedge clk);
        a = 32'h00000001; b = 32'h00000000; is_signed = 1'b0; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check_eq("rst outputs1", {27'd0, out_valid1, gt1, lt1, eq1, busy1}, 32'd0);
            check_eq("rst in_ready1", 32'(in_ready1), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst release in_ready1", 32'(in_ready1), 32'd1);
        check_eq("rst release ov1", 32'(out_valid1), 32'd0);
        run_cmp(1'b1, 32'h7FFFFFFF, 32'h80000000, 1'b1, 3'b100, 4, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
